// File: rtl/game_controller.sv
`default_nettype none
// ============================================================================
// Module   : game_controller
// Brief    : Pong match sequencer. Holds both players' lives and runs the
//            IDLE/SERVE/PLAY/POINT/OVER flow from start presses, ball-loss
//            edges and vsync frame ticks. Drives ball run/re-centre enables,
//            serve direction and game-over/winner status.
// Revision : 1.0 - initial release
// ============================================================================
module game_controller #(
  parameter int LIVES        = 3,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       start,
  input  logic       pierdei,
  input  logic       pierded,
  output logic [2:0] vidasi,
  output logic [2:0] vidasd,
  output logic       ball_run,
  output logic       ball_reset,
  output logic       serve_dir,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_SERVE = 3'd1;
  localparam logic [2:0] c_ST_PLAY  = 3'd2;
  localparam logic [2:0] c_ST_POINT = 3'd3;
  localparam logic [2:0] c_ST_OVER  = 3'd4;

  localparam logic [2:0] c_LIVES      = 3'(LIVES);
  localparam logic [7:0] c_SERVE_LAST = 8'(SERVE_FRAMES);
  localparam logic [7:0] c_POINT_LAST = 8'(POINT_FRAMES);

  logic [2:0] r_state;
  logic [7:0] r_cnt;
  logic       r_start_s1, r_start_s2, r_start_d;
  logic       r_vs_s1, r_vs_s2, r_vs_d;
  logic       r_pi_d, r_pd_d;
  logic [2:0] r_vi, r_vd;
  logic       r_run, r_brst, r_dir, r_go;
  logic [1:0] r_win;

  logic       w_start_rise, w_frame_tick, w_loss_i, w_loss_d;
  logic [7:0] w_cnt_inc;
  logic [2:0] w_state_nxt, w_vi_nxt, w_vd_nxt;
  logic       w_dir_nxt;
  logic [1:0] w_win_nxt;

  assign w_start_rise = r_start_s2 & ~r_start_d;
  assign w_frame_tick = r_vs_d & ~r_vs_s2;
  // Loss inputs are already in the clk domain; only the edge matters so a
  // held miss level is charged exactly once.
  assign w_loss_i     = pierdei & ~r_pi_d;
  assign w_loss_d     = pierded & ~r_pd_d;
  assign w_cnt_inc    = r_cnt + 8'd1;

  // Input conditioning: synchronisers and edge-detect history
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_start_s1 <= 1'b0;
      r_start_s2 <= 1'b0;
      r_start_d  <= 1'b0;
      r_vs_s1    <= 1'b0;
      r_vs_s2    <= 1'b0;
      r_vs_d     <= 1'b0;
      r_pi_d     <= 1'b0;
      r_pd_d     <= 1'b0;
    end else begin
      r_start_s1 <= start;
      r_start_s2 <= r_start_s1;
      r_start_d  <= r_start_s2;
      r_vs_s1    <= vsync;
      r_vs_s2    <= r_vs_s1;
      r_vs_d     <= r_vs_s2;
      r_pi_d     <= pierdei;
      r_pd_d     <= pierded;
    end
  end

  // Next-state, lives, serve direction and winner decisions
  always_comb begin
    w_state_nxt = r_state;
    w_vi_nxt    = r_vi;
    w_vd_nxt    = r_vd;
    w_dir_nxt   = r_dir;
    w_win_nxt   = r_win;
    case (r_state)
      c_ST_IDLE, c_ST_OVER: begin
        if (w_start_rise) begin
          w_vi_nxt    = c_LIVES;
          w_vd_nxt    = c_LIVES;
          w_win_nxt   = 2'b00;
          w_state_nxt = c_ST_SERVE;
        end
      end
      c_ST_SERVE: begin
        if (w_frame_tick && (w_cnt_inc == c_SERVE_LAST)) begin
          w_state_nxt = c_ST_PLAY;
        end
      end
      c_ST_PLAY: begin
        if (w_loss_i || w_loss_d) begin
          if (w_loss_i && (r_vi != 3'd0)) w_vi_nxt = r_vi - 3'd1;
          if (w_loss_d && (r_vd != 3'd0)) w_vd_nxt = r_vd - 3'd1;
          // Next serve goes toward the loser; a double miss keeps direction.
          if (w_loss_i && !w_loss_d) w_dir_nxt = 1'b0;
          if (w_loss_d && !w_loss_i) w_dir_nxt = 1'b1;
          w_state_nxt = c_ST_POINT;
        end
      end
      c_ST_POINT: begin
        if (w_frame_tick && (w_cnt_inc == c_POINT_LAST)) begin
          if ((r_vi == 3'd0) || (r_vd == 3'd0)) begin
            // bit1 = right wins (left out), bit0 = left wins (right out)
            w_win_nxt   = {(r_vi == 3'd0), (r_vd == 3'd0)};
            w_state_nxt = c_ST_OVER;
          end else begin
            w_state_nxt = c_ST_SERVE;
          end
        end
      end
      default: w_state_nxt = c_ST_IDLE;
    endcase
  end

  // State, frame counter and registered outputs decoded from the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_ST_IDLE;
      r_cnt   <= 8'd0;
      r_vi    <= c_LIVES;
      r_vd    <= c_LIVES;
      r_dir   <= 1'b0;
      r_win   <= 2'b00;
      r_run   <= 1'b0;
      r_brst  <= 1'b1;
      r_go    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state) begin
        r_cnt <= 8'd0;
      end else if (w_frame_tick) begin
        r_cnt <= w_cnt_inc;
      end
      r_vi   <= w_vi_nxt;
      r_vd   <= w_vd_nxt;
      r_dir  <= w_dir_nxt;
      r_win  <= w_win_nxt;
      r_run  <= (w_state_nxt == c_ST_PLAY);
      r_brst <= (w_state_nxt == c_ST_IDLE) || (w_state_nxt == c_ST_SERVE) ||
                (w_state_nxt == c_ST_OVER);
      r_go   <= (w_state_nxt == c_ST_OVER);
    end
  end

  assign vidasi     = r_vi;
  assign vidasd     = r_vd;
  assign ball_run   = r_run;
  assign ball_reset = r_brst;
  assign serve_dir  = r_dir;
  assign game_over  = r_go;
  assign winner     = r_win;

endmodule
`default_nettype wire

// File: tb/tb_game_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_controller
// Brief    : Self-checking bench for game_controller. Expected output sets are
//            queued as stimulus is applied and popped once the DUT has had
//            time to respond.
// Revision : 1.0 - initial release
// ============================================================================
module tb_game_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       vsync = 1'b1;
  logic       start = 1'b0;
  logic       pierdei = 1'b0;
  logic       pierded = 1'b0;
  logic [2:0] vidasi, vidasd;
  logic       ball_run, ball_reset, serve_dir, game_over;
  logic [1:0] winner;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string tag;
    int    vi, vd, run, brst, dir, go, win;
  } exp_t;
  exp_t sb_q[$];

  game_controller #(.LIVES(3), .SERVE_FRAMES(60), .POINT_FRAMES(90)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .vsync      (vsync),
    .start      (start),
    .pierdei    (pierdei),
    .pierded    (pierded),
    .vidasi     (vidasi),
    .vidasd     (vidasd),
    .ball_run   (ball_run),
    .ball_reset (ball_reset),
    .serve_dir  (serve_dir),
    .game_over  (game_over),
    .winner     (winner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input int vi, input int vd, input int run,
                          input int brst, input int dir, input int go, input int win);
    exp_t e;
    e.tag = tag; e.vi = vi; e.vd = vd; e.run = run; e.brst = brst;
    e.dir = dir; e.go = go; e.win = win;
    sb_q.push_back(e);
  endtask

  task automatic sb_compare();
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 8'd1, 8'd0);
    end else begin
      e = sb_q.pop_front();
      chk({e.tag, ".vidasi"},     8'(vidasi),     8'(e.vi));
      chk({e.tag, ".vidasd"},     8'(vidasd),     8'(e.vd));
      chk({e.tag, ".ball_run"},   8'(ball_run),   8'(e.run));
      chk({e.tag, ".ball_reset"}, 8'(ball_reset), 8'(e.brst));
      chk({e.tag, ".serve_dir"},  8'(serve_dir),  8'(e.dir));
      chk({e.tag, ".game_over"},  8'(game_over),  8'(e.go));
      chk({e.tag, ".winner"},     8'(winner),     8'(e.win));
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      vsync = 1'b0; clks(4);
      vsync = 1'b1; clks(4);
    end
  endtask

  task automatic press_start();
    start = 1'b1; clks(3);
    start = 1'b0; clks(3);
  endtask

  // sel: 1 = left misses, 2 = right misses, 3 = both in the same clock
  task automatic miss(input int sel, input int hold);
    pierdei = sel[0];
    pierded = sel[1];
    clks(hold);
    pierdei = 1'b0;
    pierded = 1'b0;
    clks(2);
  endtask

  // Watchdog: the bench must never hang
  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ok;
    // 1: reset, then idle for 10 frames
    clks(3);
    reset = 1'b1;
    frames(10);
    push_exp("t1_idle", 3, 3, 0, 1, 0, 0, 0);
    sb_compare();
    pierdei = 1'b1; clks(2); pierdei = 1'b0; clks(2);
    push_exp("t1_idle_loss", 3, 3, 0, 1, 0, 0, 0);
    sb_compare();

    // 2: start -> SERVE, PLAY on the 60th frame tick
    press_start();
    push_exp("t2_serve", 3, 3, 0, 1, 0, 0, 0);
    sb_compare();
    frames(59);
    push_exp("t2_serve59", 3, 3, 0, 1, 0, 0, 0);
    sb_compare();
    frames(1);
    push_exp("t2_play", 3, 3, 1, 0, 0, 0, 0);
    sb_compare();

    // 3: right miss held 100 clk counts once; POINT lasts 90 frames
    miss(2, 100);
    push_exp("t3_point", 3, 2, 0, 0, 1, 0, 0);
    sb_compare();
    frames(89);
    push_exp("t3_point89", 3, 2, 0, 0, 1, 0, 0);
    sb_compare();
    frames(1);
    push_exp("t3_serve", 3, 2, 0, 1, 1, 0, 0);
    sb_compare();

    // 4: left loses three points -> OVER, right wins
    for (int k = 0; k < 3; k++) begin
      frames(60);
      miss(1, 2);
      push_exp($sformatf("t4_point%0d", k), 2 - k, 2, 0, 0, 0, 0, 0);
      sb_compare();
      frames(90);
    end
    push_exp("t4_over", 0, 2, 0, 1, 0, 1, 2);
    sb_compare();
    frames(5);
    push_exp("t4_over_hold", 0, 2, 0, 1, 0, 1, 2);
    sb_compare();
    start = 1'b1;
    ok = 0;
    for (int c = 0; c < 4 && ok == 0; c++) begin
      @(negedge clk);
      if (game_over == 1'b0) ok = 1;
    end
    chk("t4_serve_in_4clk", 8'(ok), 8'd1);
    start = 1'b0; clks(3);
    push_exp("t4_restart", 3, 3, 0, 1, 0, 0, 0);
    sb_compare();

    // 5: simultaneous misses down to 0/0 -> draw
    for (int k = 0; k < 3; k++) begin
      frames(60);
      miss(3, 2);
      push_exp($sformatf("t5_point%0d", k), 2 - k, 2 - k, 0, 0, 0, 0, 0);
      sb_compare();
      frames(90);
    end
    push_exp("t5_over", 0, 0, 0, 1, 0, 1, 3);
    sb_compare();

    // 6: misses ignored outside PLAY, start ignored in POINT, reset mid-PLAY
    press_start();
    miss(1, 2);
    push_exp("t6_serve_loss", 3, 3, 0, 1, 0, 0, 0);
    sb_compare();
    frames(60);
    miss(2, 2);
    push_exp("t6_point", 3, 2, 0, 0, 1, 0, 0);
    sb_compare();
    miss(1, 2);
    press_start();
    push_exp("t6_point_loss", 3, 2, 0, 0, 1, 0, 0);
    sb_compare();
    frames(90);
    push_exp("t6_serve", 3, 2, 0, 1, 1, 0, 0);
    sb_compare();
    frames(60);
    push_exp("t6_play", 3, 2, 1, 0, 1, 0, 0);
    sb_compare();
    reset = 1'b0;
    #1;
    push_exp("t6_reset", 3, 3, 0, 1, 0, 0, 0);
    sb_compare();
    clks(2);
    reset = 1'b1;
    frames(70);
    push_exp("t6_idle_after", 3, 3, 0, 1, 0, 0, 0);
    sb_compare();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
